midi_tx_encoder: RTL and testbench
==================================

Name: midi_tx_encoder

Overview:
- Transmit-side counterpart of the MIDI decode path: accepts Note On/Off events over a valid/ready handshake and buffers them in a small FIFO.
- Encodes each event into MIDI channel-voice bytes and serializes them as 31250-baud UART frames on the MIDI OUT pin.
- Mirrors every completed byte on a parallel byte/strobe pair, so a bench or loopback can feed a MIDI decoder directly.

Parameters:
- pBaudDiv, 1536, clock cycles per serial bit (48 MHz / 31250); legal range >= 2.
- pFifoDepth, 4, event FIFO entries; power of 2, >= 2.
- pSim, "no", "yes" has no functional effect (reserved for bench hooks only).

Ports:
- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iEvtValid  in  1  event offered.
- oEvtReady  out  1  FIFO can accept; transfer when iEvtValid & oEvtReady at a rising edge.
- iEvtNoteOn  in  1  1 = Note On (0x9n), 0 = Note Off (0x8n).
- iEvtChannel  in  4  MIDI channel n.
- iEvtNote  in  7  note number.
- iEvtVelocity  in  7  velocity.
- oMidiTx  out  1  serial MIDI out; idle high.
- oByteData  out  8  last fully transmitted byte.
- oByteValid  out  1  1-cycle pulse when oByteData updates.
- oBusy  out  1  high while FIFO non-empty or a frame is in progress.

Behaviour:
- Reset values:
  - oMidiTx = 1, oEvtReady = 1, oByteData = 0x00, oByteValid = 0, oBusy = 0.
  - FIFO empty; FSM in IDLE; bit/baud counters 0.
- FIFO:
  - Push on handshake. oEvtReady = not full, registered.
  - Push and pop in the same cycle are legal when not full; count is unchanged.
  - oEvtReady deasserts the cycle after the push that fills the FIFO.
  - Order is preserved; no event is dropped or duplicated.
- Status byte = {1'b1, ~iEvtNoteOn ? 3'b000 : 3'b001, channel}, i.e. 0x8n or 0x9n.
- Data bytes are {1'b0, note} and {1'b0, velocity}. Velocity 0 on Note On is sent unchanged, with no conversion.
- FSM states: IDLE, LOAD, SEND_STATUS, SEND_D1, SEND_D2.
  - IDLE -> LOAD when FIFO is non-empty.
  - LOAD pops the head event into the holding register, then -> SEND_STATUS.
  - Each SEND_* state transmits one frame, then advances.
  - SEND_D2 -> LOAD if FIFO is non-empty, else IDLE.
- Frame format:
  - start bit 0, 8 data bits LSB first, stop bit 1.
  - Each bit is held exactly pBaudDiv cycles, so a frame is 10*pBaudDiv cycles.
  - Back-to-back frames have zero idle gap: the next start bit follows the stop bit directly.
- Latency:
  - Event accepted at edge N on an empty, idle block: FSM enters LOAD at N+1.
  - oMidiTx falls (start bit) at edge N+2.
- Byte strobe: at the edge ending each stop bit, oByteData is loaded with that byte and oByteValid = 1 for exactly one cycle.
- oBusy:
  - Rises the cycle after the first accept.
  - Falls the cycle after the final stop bit ends with the FIFO empty.
- Reset mid-operation:
  - Async reset forces oMidiTx high immediately.
  - The partial frame is abandoned and no strobe is produced for it.
  - The FIFO contents are discarded.

Optional Feature:
- MIDI_RUNNING_STATUS_EN defined:
  - The block holds a last-status register, cleared by reset to invalid.
  - When the popped event's status equals last-status, SEND_STATUS is skipped (LOAD -> SEND_D1) and no status frame or strobe is emitted.
  - Otherwise the status byte is sent and last-status is updated.
- Undefined: every message is exactly 3 frames; the register does not exist.

Test Plan:
1. Reset, pBaudDiv=4:
   - oMidiTx=1, oEvtReady=1, oBusy=0, oByteValid=0, oByteData=0x00 throughout reset.
   - Same values for 20 cycles after release.
2. Single event, Note On ch0, note 0x36, vel 0x30:
   - Start bit 2 cycles after accept.
   - Strobes carry 0x90, 0x36, 0x30, spaced 40 cycles apart.
   - Serial bits decode to the same bytes.
   - oBusy low 120 cycles after the start bit.
3. Note Off ch3, note 0x44, vel 0x20:
   - Bytes 0x83, 0x44, 0x20.
   - Note On with vel 0x00 is sent as 0x9n, xx, 0x00.
4. Burst: iEvtValid held high for 8 distinct events with pFifoDepth=4:
   - oEvtReady drops while full.
   - All 8 events are emitted in order, 24 bytes, with no gaps between frames.
5. Running status:
   - Events Note On ch0 0x36/0x30 then Note On ch0 0x40/0x20.
   - With MIDI_RUNNING_STATUS_EN: bytes 0x90, 0x36, 0x30, 0x40, 0x20.
   - Without it: 0x90, 0x36, 0x30, 0x90, 0x40, 0x20.
   - A following Note Off ch0 re-emits status 0x80.
6. Reset asserted during bit 4 of the second frame:
   - oMidiTx goes high in the same cycle.
   - No further strobes; FIFO empties.
   - After release, a new event transmits normally with its full status byte.

Source files
------------

// File: rtl/midi_tx_encoder.sv
// ---------------------------------------------------------------------------
// midi_tx_encoder
//
// Purpose:
//   Accepts MIDI Note On / Note Off events over a valid/ready handshake and
//   buffers them in a small FIFO. Each event is encoded as a status byte
//   (0x8n / 0x9n) followed by the note and velocity data bytes. The bytes are
//   sent as 31250-baud UART frames on the MIDI OUT pin: start bit, 8 data
//   bits LSB first, stop bit, with no idle gap between frames. Every
//   completed byte is also mirrored on a parallel byte/strobe pair.
//
// Optional feature (compile-time macro MIDI_RUNNING_STATUS_EN):
//   When defined, a last-status register (reset to invalid) lets the encoder
//   omit the status frame when it repeats the previously sent status byte.
//   When undefined, every message is exactly three frames.
//
// Parameters:
//   pBaudDiv    clock cycles per serial bit (>= 2)
//   pFifoDepth  event FIFO entries (power of 2, >= 2)
//   pSim        "no"/"yes", no functional effect
//
// Ports:
//   iCLK          system clock, rising edge
//   iRST          asynchronous active-high reset
//   iEvtValid     event offered
//   oEvtReady     FIFO can accept (registered, not full)
//   iEvtNoteOn    1 = Note On, 0 = Note Off
//   iEvtChannel   MIDI channel (4 bits)
//   iEvtNote      note number (7 bits)
//   iEvtVelocity  velocity (7 bits)
//   oMidiTx       serial MIDI out, idle high
//   oByteData     last fully transmitted byte
//   oByteValid    one-cycle pulse when oByteData updates
//   oBusy         FIFO non-empty or a frame in progress
// ---------------------------------------------------------------------------
module midi_tx_encoder #(
  parameter int    pBaudDiv   = 1536,
  parameter int    pFifoDepth = 4,
  parameter string pSim       = "no"
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iEvtValid,
  output logic       oEvtReady,
  input  logic       iEvtNoteOn,
  input  logic [3:0] iEvtChannel,
  input  logic [6:0] iEvtNote,
  input  logic [6:0] iEvtVelocity,
  output logic       oMidiTx,
  output logic [7:0] oByteData,
  output logic       oByteValid,
  output logic       oBusy
);

  // pSim selects between identical values; it only keeps the bench hook
  // parameter referenced without changing behaviour.
  localparam int BaudDiv = (pSim == "yes") ? pBaudDiv : pBaudDiv;
  localparam int BaudW   = $clog2(BaudDiv);
  localparam int PtrW    = $clog2(pFifoDepth);

  localparam logic [BaudW-1:0] BaudLast   = BaudW'(BaudDiv - 1);
  localparam logic [BaudW-1:0] BaudPenult = BaudW'(BaudDiv - 2);
  localparam logic [PtrW:0]    FifoFull   = (PtrW + 1)'(pFifoDepth);

  typedef struct packed {
    logic       note_on;
    logic [3:0] channel;
    logic [6:0] note;
    logic [6:0] velocity;
  } event_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND_STATUS,
    SEND_D1,
    SEND_D2
  } state_t;

  state_t            state;
  event_t            fifo_mem [pFifoDepth];
  logic [PtrW-1:0]   wr_ptr;
  logic [PtrW-1:0]   rd_ptr;
  logic [PtrW:0]     count;
  logic [PtrW:0]     count_next;
  logic              push;
  logic              pop;
  event_t            head;
  logic [7:0]        head_status;
  logic              skip_status;

  logic [BaudW-1:0]  baud_cnt;
  logic [3:0]        bit_idx;
  logic [7:0]        tx_byte;
  logic [6:0]        hold_note;
  logic [6:0]        hold_vel;

  assign push        = iEvtValid & oEvtReady;
  // LOAD always lasts exactly one cycle and is only entered with the FIFO
  // non-empty, so it doubles as the pop strobe.
  assign pop         = (state == LOAD);
  assign head        = fifo_mem[rd_ptr];
  assign head_status = {1'b1, 2'b00, head.note_on, head.channel};
  assign count_next  = count + (PtrW + 1)'(push) - (PtrW + 1)'(pop);

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;

  // A cleared last-status (0x00) never matches a real status byte, which
  // always has bit 7 set.
  assign skip_status = (head_status == last_status);
`else
  assign skip_status = 1'b0;
`endif

  // Event storage; contents need no reset because the pointers define
  // which entries are live.
  always_ff @(posedge iCLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{note_on:  iEvtNoteOn,
                            channel:  iEvtChannel,
                            note:     iEvtNote,
                            velocity: iEvtVelocity};
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      oEvtReady <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      oEvtReady <= (count_next != FifoFull);
    end
  end

  // Encoder / serializer FSM. A frame starts by driving the start bit and
  // loading tx_byte; bit_idx 0 is the start bit, 1..8 data, 9 the stop bit.
  // When another event is queued, SEND_D2 hands over to LOAD during the last
  // cycle of its stop bit, so LOAD closes that stop bit (strobe included)
  // and starts the next frame on the same edge with no idle gap.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      tx_byte    <= '0;
      hold_note  <= '0;
      hold_vel   <= '0;
      oMidiTx    <= 1'b1;
      oByteData  <= 8'h00;
      oByteValid <= 1'b0;
      oBusy      <= 1'b0;
`ifdef MIDI_RUNNING_STATUS_EN
      last_status <= 8'h00;
`endif
    end else begin
      oByteValid <= 1'b0;
      oBusy      <= 1'b1;
      case (state)
        IDLE: begin
          oMidiTx  <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (count != '0) begin
            state <= LOAD;
          end else begin
            oBusy <= (count_next != '0);
          end
        end

        LOAD: begin
          if (bit_idx == 4'd9) begin
            oByteData  <= tx_byte;
            oByteValid <= 1'b1;
          end
          hold_note <= head.note;
          hold_vel  <= head.velocity;
          oMidiTx   <= 1'b0;
          baud_cnt  <= '0;
          bit_idx   <= '0;
          if (skip_status) begin
            tx_byte <= {1'b0, head.note};
            state   <= SEND_D1;
          end else begin
            tx_byte <= head_status;
            state   <= SEND_STATUS;
`ifdef MIDI_RUNNING_STATUS_EN
            last_status <= head_status;
`endif
          end
        end

        default: begin
          if (baud_cnt != BaudLast) begin
            baud_cnt <= baud_cnt + 1'b1;
            if (state == SEND_D2 && bit_idx == 4'd9 &&
                baud_cnt == BaudPenult && count != '0) begin
              state <= LOAD;
            end
          end else if (bit_idx != 4'd9) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 1'b1;
            oMidiTx  <= (bit_idx == 4'd8) ? 1'b1 : tx_byte[bit_idx[2:0]];
          end else begin
            oByteData  <= tx_byte;
            oByteValid <= 1'b1;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            case (state)
              SEND_STATUS: begin
                tx_byte <= {1'b0, hold_note};
                oMidiTx <= 1'b0;
                state   <= SEND_D1;
              end
              SEND_D1: begin
                tx_byte <= {1'b0, hold_vel};
                oMidiTx <= 1'b0;
                state   <= SEND_D2;
              end
              default: begin
                oMidiTx <= 1'b1;
                oBusy   <= (count_next != '0);
                state   <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_tx_encoder.sv
// ---------------------------------------------------------------------------
// tb_midi_tx_encoder
//
// Self-checking bench for midi_tx_encoder with a short bit period. Accepted
// events are expanded into the MIDI byte stream they must produce; the byte
// strobe and a bit-level UART decoder of oMidiTx are both checked against
// that stream, and oBusy is checked every cycle against "bytes still owed".
// Directed sections pin literal byte sequences and timing.
// ---------------------------------------------------------------------------
module tb_midi_tx_encoder;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BAUD;

  logic       iCLK         = 1'b0;
  logic       iRST         = 1'b1;
  logic       iEvtValid    = 1'b0;
  logic       iEvtNoteOn   = 1'b0;
  logic [3:0] iEvtChannel  = 4'h0;
  logic [6:0] iEvtNote     = 7'h00;
  logic [6:0] iEvtVelocity = 7'h00;
  logic       oEvtReady;
  logic       oMidiTx;
  logic [7:0] oByteData;
  logic       oByteValid;
  logic       oBusy;

  midi_tx_encoder #(
    .pBaudDiv   (BAUD),
    .pFifoDepth (DEPTH),
    .pSim       ("yes")
  ) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iEvtValid    (iEvtValid),
    .oEvtReady    (oEvtReady),
    .iEvtNoteOn   (iEvtNoteOn),
    .iEvtChannel  (iEvtChannel),
    .iEvtNote     (iEvtNote),
    .iEvtVelocity (iEvtVelocity),
    .oMidiTx      (oMidiTx),
    .oByteData    (oByteData),
    .oByteValid   (oByteValid),
    .oBusy        (oBusy)
  );

  always #5 iCLK = ~iCLK;

  int         checks = 0;
  int         errors = 0;
  int         cycle  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ser_q[$];
  logic [7:0] model_last_status = 8'h00;
  logic [7:0] log_q[$];
  int         log_t[$];
  bit         saw_not_ready = 1'b0;
  bit         rx_active = 1'b0;
  int         rx_k = 0;
  logic [7:0] rx_byte = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expands one accepted event into the MIDI bytes it must produce.
  function automatic void modelAccept(input bit note_on, input logic [3:0] ch,
                                      input logic [6:0] note, input logic [6:0] vel);
    logic [7:0] status;
    status = 8'h80 + (note_on ? 8'h10 : 8'h00) + {4'h0, ch};
`ifdef MIDI_RUNNING_STATUS_EN
    if (status != model_last_status) begin
      exp_q.push_back(status);
      ser_q.push_back(status);
      model_last_status = status;
    end
`else
    exp_q.push_back(status);
    ser_q.push_back(status);
`endif
    exp_q.push_back({1'b0, note});
    ser_q.push_back({1'b0, note});
    exp_q.push_back({1'b0, vel});
    ser_q.push_back({1'b0, vel});
  endfunction

  // Handshake observer feeding the model.
  always @(posedge iCLK) begin
    cycle++;
    if (!iRST && iEvtValid && oEvtReady)
      modelAccept(iEvtNoteOn, iEvtChannel, iEvtNote, iEvtVelocity);
  end

  // Per-cycle compare: byte strobe, busy, idle line, and serial decoding.
  always @(negedge iCLK) begin
    if (iRST) begin
      exp_q.delete();
      ser_q.delete();
      model_last_status = 8'h00;
      rx_active = 1'b0;
    end else begin
      if (oByteValid) begin
        log_q.push_back(oByteData);
        log_t.push_back(cycle);
        checkOutput("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          checkOutput("strobe_byte", 32'(oByteData), 32'(exp_q.pop_front()));
      end
      checkOutput("busy", 32'(oBusy), 32'(exp_q.size() != 0));
      if (exp_q.size() == 0)
        checkOutput("tx_idle_high", 32'(oMidiTx), 32'd1);

      if (!rx_active && oMidiTx == 1'b0) begin
        rx_active = 1'b1;
        rx_k      = 0;
        rx_byte   = 8'h00;
      end
      if (rx_active) begin
        if (rx_k % BAUD == BAUD / 2) begin
          if (rx_k / BAUD == 0) begin
            checkOutput("rx_start_bit", 32'(oMidiTx), 32'd0);
          end else if (rx_k / BAUD <= 8) begin
            rx_byte[rx_k / BAUD - 1] = oMidiTx;
          end else begin
            checkOutput("rx_stop_bit", 32'(oMidiTx), 32'd1);
            checkOutput("rx_frame_expected", 32'(ser_q.size() != 0), 32'd1);
            if (ser_q.size() != 0)
              checkOutput("rx_byte", 32'(rx_byte), 32'(ser_q.pop_front()));
          end
        end
        rx_k++;
        if (rx_k == FRAME) rx_active = 1'b0;
      end
    end
  end

  // Offers one event at the current negedge and returns on the negedge after
  // it was accepted; hold_valid keeps iEvtValid high for a following call.
  task automatic applyStimulus(input bit note_on, input logic [3:0] ch,
                               input logic [6:0] note, input logic [6:0] vel,
                               input bit hold_valid);
    int wait_cnt = 0;
    iEvtValid    = 1'b1;
    iEvtNoteOn   = note_on;
    iEvtChannel  = ch;
    iEvtNote     = note;
    iEvtVelocity = vel;
    while (!oEvtReady && wait_cnt < 2000) begin
      saw_not_ready = 1'b1;
      @(negedge iCLK);
      wait_cnt++;
    end
    if (!oEvtReady) checkOutput("ready_timeout", 32'(oEvtReady), 32'd1);
    @(negedge iCLK);
    if (!hold_valid) iEvtValid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge iCLK);
    while ((oBusy || ser_q.size() != 0) && n < 5000) begin
      @(negedge iCLK);
      n++;
    end
    if (oBusy) checkOutput("idle_timeout", 32'(oBusy), 32'd0);
    repeat (3) @(negedge iCLK);
  endtask

  task automatic resetDut();
    iEvtValid = 1'b0;
    iRST      = 1'b1;
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
    @(negedge iCLK);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_tx"},    32'(oMidiTx),    32'd1);
    checkOutput({tag, "_ready"}, 32'(oEvtReady),  32'd1);
    checkOutput({tag, "_busy"},  32'(oBusy),      32'd0);
    checkOutput({tag, "_valid"}, 32'(oByteValid), 32'd0);
    checkOutput({tag, "_data"},  32'(oByteData),  32'h00);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int         start_cycle;
    int         n_exp;
    int         n_log;
    logic [7:0] prev;
    logic [7:0] st;
    bit         b_on  [8];
    logic [3:0] b_ch  [8];
    logic [6:0] b_note[8];
    logic [6:0] b_vel [8];
    logic [7:0] exp5[$];

    // 1. reset values, during and after reset
    repeat (3) begin
      @(negedge iCLK);
      checkIdleOutputs("reset");
    end
    iRST = 1'b0;
    repeat (20) begin
      @(negedge iCLK);
      checkIdleOutputs("post_reset");
    end

    // 2. single Note On: latency, bytes, spacing, busy fall
    log_q.delete();
    log_t.delete();
    applyStimulus(1'b1, 4'h0, 7'h36, 7'h30, 1'b0);
    checkOutput("lat_n0_tx", 32'(oMidiTx), 32'd1);
    @(negedge iCLK);
    checkOutput("lat_n1_tx", 32'(oMidiTx), 32'd1);
    @(negedge iCLK);
    checkOutput("lat_start_bit", 32'(oMidiTx), 32'd0);
    start_cycle = cycle;
    repeat (3 * FRAME - 1) @(negedge iCLK);
    checkOutput("busy_before_end", 32'(oBusy), 32'd1);
    @(negedge iCLK);
    checkOutput("busy_after_end", 32'(oBusy), 32'd0);
    repeat (3) @(negedge iCLK);
    checkOutput("single_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      checkOutput("single_b0", 32'(log_q[0]), 32'h90);
      checkOutput("single_b1", 32'(log_q[1]), 32'h36);
      checkOutput("single_b2", 32'(log_q[2]), 32'h30);
      checkOutput("single_gap01", 32'(log_t[1] - log_t[0]), 32'(FRAME));
      checkOutput("single_gap12", 32'(log_t[2] - log_t[1]), 32'(FRAME));
      checkOutput("single_end", 32'(log_t[2] - start_cycle), 32'(3 * FRAME));
    end

    // 3. Note Off and Note On with velocity zero
    log_q.delete();
    log_t.delete();
    applyStimulus(1'b0, 4'h3, 7'h44, 7'h20, 1'b0);
    applyStimulus(1'b1, 4'h5, 7'h3C, 7'h00, 1'b0);
    waitIdle();
    checkOutput("off_count", 32'(log_q.size()), 32'd6);
    if (log_q.size() == 6) begin
      checkOutput("off_b0", 32'(log_q[0]), 32'h83);
      checkOutput("off_b1", 32'(log_q[1]), 32'h44);
      checkOutput("off_b2", 32'(log_q[2]), 32'h20);
      checkOutput("vel0_b0", 32'(log_q[3]), 32'h95);
      checkOutput("vel0_b1", 32'(log_q[4]), 32'h3C);
      checkOutput("vel0_b2", 32'(log_q[5]), 32'h00);
    end

    // 4. burst of 8 distinct events with valid held high
    resetDut();
    log_q.delete();
    log_t.delete();
    saw_not_ready = 1'b0;
    n_exp = 0;
    prev  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b_on[i]   = 1'($urandom_range(0, 1));
      b_ch[i]   = 4'($urandom_range(0, 15));
      b_note[i] = 7'(i * 16 + $urandom_range(0, 15));
      b_vel[i]  = 7'($urandom_range(0, 127));
      st = 8'h80 + (b_on[i] ? 8'h10 : 8'h00) + {4'h0, b_ch[i]};
`ifdef MIDI_RUNNING_STATUS_EN
      if (st != prev) n_exp++;
`else
      n_exp++;
`endif
      prev  = st;
      n_exp = n_exp + 2;
    end
    for (int i = 0; i < 8; i++)
      applyStimulus(b_on[i], b_ch[i], b_note[i], b_vel[i], (i < 7));
    checkOutput("burst_ready_drop", 32'(saw_not_ready), 32'd1);
    waitIdle();
    checkOutput("burst_count", 32'(log_q.size()), 32'(n_exp));
    for (int i = 1; i < log_t.size(); i++)
      checkOutput("burst_no_gap", 32'(log_t[i] - log_t[i-1]), 32'(FRAME));

    // randomized stream with random idle gaps
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)), 1'b0);
      repeat ($urandom_range(0, 60)) @(negedge iCLK);
    end
    waitIdle();

    // 5. running status sequence
    resetDut();
    log_q.delete();
    log_t.delete();
    applyStimulus(1'b1, 4'h0, 7'h36, 7'h30, 1'b0);
    applyStimulus(1'b1, 4'h0, 7'h40, 7'h20, 1'b0);
    applyStimulus(1'b0, 4'h0, 7'h40, 7'h00, 1'b0);
    waitIdle();
`ifdef MIDI_RUNNING_STATUS_EN
    exp5 = '{8'h90, 8'h36, 8'h30, 8'h40, 8'h20, 8'h80, 8'h40, 8'h00};
`else
    exp5 = '{8'h90, 8'h36, 8'h30, 8'h90, 8'h40, 8'h20, 8'h80, 8'h40, 8'h00};
`endif
    checkOutput("rs_count", 32'(log_q.size()), 32'(exp5.size()));
    for (int i = 0; i < exp5.size() && i < log_q.size(); i++)
      checkOutput("rs_byte", 32'(log_q[i]), 32'(exp5[i]));

    // 6. reset during bit 4 of the second frame
    resetDut();
    log_q.delete();
    log_t.delete();
    applyStimulus(1'b1, 4'h0, 7'h36, 7'h30, 1'b0);
    applyStimulus(1'b0, 4'h2, 7'h11, 7'h22, 1'b0);
    for (int n = 0; n < 1000 && log_q.size() == 0; n++) @(negedge iCLK);
    checkOutput("mid_first_strobe", 32'(log_q.size()), 32'd1);
    repeat (4 * BAUD + 1) @(negedge iCLK);
    checkOutput("mid_pre_reset_tx", 32'(oMidiTx), 32'd0);
    iRST = 1'b1;
    #1;
    checkOutput("mid_async_tx", 32'(oMidiTx), 32'd1);
    checkOutput("mid_async_busy", 32'(oBusy), 32'd0);
    checkOutput("mid_async_ready", 32'(oEvtReady), 32'd1);
    repeat (3) @(negedge iCLK);
    iRST  = 1'b0;
    n_log = log_q.size();
    repeat (30) @(negedge iCLK);
    checkOutput("mid_no_strobe", 32'(log_q.size()), 32'(n_log));
    checkOutput("mid_fifo_empty_busy", 32'(oBusy), 32'd0);
    checkOutput("mid_fifo_empty_ready", 32'(oEvtReady), 32'd1);
    log_q.delete();
    log_t.delete();
    applyStimulus(1'b1, 4'h0, 7'h36, 7'h30, 1'b0);
    waitIdle();
    checkOutput("after_rst_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      checkOutput("after_rst_b0", 32'(log_q[0]), 32'h90);
      checkOutput("after_rst_b1", 32'(log_q[1]), 32'h36);
      checkOutput("after_rst_b2", 32'(log_q[2]), 32'h30);
    end

    checkOutput("leftover_bytes", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
